// File: rtl/adder_pipe_vr.sv
// Pipelined add/subtract unit with valid/ready handshakes, optional saturation and carry/overflow flags.
// All arithmetic happens on accept; later stages are elastic delay registers whose bubbles collapse.
module adder_pipe_vr #(
  parameter int N      = 8,
  parameter int STAGES = 2,
  parameter int SIGNED = 0
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] operand1,
  input  logic [N-1:0] operand2,
  input  logic         op_sub,
  input  logic         sat_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  if (N < 2 || STAGES < 1) begin : g_param_check
    $error("adder_pipe_vr: illegal parameters N=%0d STAGES=%0d", N, STAGES);
  end

  localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  // Returns {carry_or_borrow, overflow, wrapped_result}.
  function automatic logic [N+1:0] arith(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sub);
    logic [N:0] raw;
    logic       sovf;
    logic       ovf;
    if (sub) begin
      raw  = {1'b0, a} - {1'b0, b};
      sovf = (a[N-1] != b[N-1]) && (raw[N-1] != a[N-1]);
    end else begin
      raw  = {1'b0, a} + {1'b0, b};
      sovf = (a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]);
    end
    ovf = (SIGNED != 0) ? sovf : raw[N];
    return {raw[N], ovf, raw[N-1:0]};
  endfunction

  // On signed overflow the true result always carries operand1's sign.
  function automatic logic [N-1:0] saturate(input logic [N-1:0] wrapped, input logic [N-1:0] a,
                                            input logic sub, input logic ovf, input logic sat);
    if (!sat || !ovf) return wrapped;
    if (SIGNED != 0) return a[N-1] ? SMIN : SMAX;
    return sub ? '0 : '1;
  endfunction

  logic [N+1:0] arith_p0;
  logic [N-1:0] res_p0;

  assign arith_p0 = arith(operand1, operand2, op_sub);
  assign res_p0   = saturate(arith_p0[N-1:0], operand1, op_sub, arith_p0[N], sat_en);

  logic [STAGES:1] vld_p;
  logic [STAGES:1] carry_p;
  logic [STAGES:1] ovf_p;
  logic [N-1:0]    res_p [1:STAGES];
  logic [STAGES:1] rdy;

  // A stage may load when it is empty or everything downstream can move.
  always_comb begin
    logic downstream_ok;
    rdy           = '0;
    downstream_ok = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      downstream_ok = downstream_ok || !vld_p[k];
      rdy[k]        = downstream_ok;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p   <= '0;
      carry_p <= '0;
      ovf_p   <= '0;
      for (int k = 1; k <= STAGES; k++) res_p[k] <= '0;
    end else begin
      // stage 1: computed operands enter
      if (rdy[1]) begin
        vld_p[1]   <= in_valid;
        res_p[1]   <= res_p0;
        carry_p[1] <= arith_p0[N+1];
        ovf_p[1]   <= arith_p0[N];
      end
      // stages 2..STAGES: delay registers
      for (int k = 2; k <= STAGES; k++) begin
        if (rdy[k]) begin
          vld_p[k]   <= vld_p[k-1];
          res_p[k]   <= res_p[k-1];
          carry_p[k] <= carry_p[k-1];
          ovf_p[k]   <= ovf_p[k-1];
        end
      end
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld_p[STAGES];
  assign result    = res_p[STAGES];
  assign carry_out = carry_p[STAGES];
  assign overflow  = ovf_p[STAGES];

endmodule

// File: doc/adder_pipe_vr.md
Name: adder_pipe_vr

Overview:
Parametrised, pipelined two-operand add/subtract unit. Successor to the fixed 2-cycle N-bit adder. Adds:
- valid/ready handshakes on input and output, with backpressure
- configurable pipeline depth
- signed/unsigned arithmetic
- optional saturation
- carry/borrow and overflow flags

It sits between a producer and consumer in the datapath and sustains one operation per cycle when the consumer is not stalling.

Parameters:
N, 8, operand/result width in bits (N >= 2)
STAGES, 2, pipeline depth = accept-to-output latency in cycles (STAGES >= 1)
SIGNED, 0, 0 = unsigned two's-complement-free arithmetic, 1 = signed two's-complement

Ports:
clock  in  1  single clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  operand set present
in_ready  out  1  unit can accept an operand set this cycle
operand1  in  N  first operand
operand2  in  N  second operand
op_sub  in  1  0 = operand1+operand2, 1 = operand1-operand2
sat_en  in  1  1 = saturate on overflow, 0 = wrap modulo 2^N
out_valid  out  1  result present
out_ready  in  1  consumer accepts result this cycle
result  out  N  arithmetic result
carry_out  out  1  unsigned carry (add) or borrow (sub)
overflow  out  1  result not representable in N bits under the SIGNED interpretation

Behaviour:
- Clock and reset: one clock `clock`; reset `reset_n` is asynchronous, active-low. While reset_n=0:
  - all stage valid bits = 0; all data/flag registers = 0
  - out_valid=0, result=0, carry_out=0, overflow=0
- Transfers: an input transfer occurs on a rising edge with in_valid&&in_ready. An output transfer occurs with out_valid&&out_ready.
- Pipeline structure: stages 1..STAGES, each with a valid bit v[k] and data/flag registers. Stage STAGES drives the outputs directly (registered outputs, no combinational path from operands to result).
- Computation: performed entirely when data enters stage 1 (op_sub, sat_en, operands sampled at accept). Stages 2..STAGES are delay registers.
- Ready chain: rdy[STAGES] = !v[STAGES] || out_ready; rdy[k] = !v[k] || rdy[k+1]; in_ready = rdy[1]. Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Stage update: stage k loads from stage k-1 (or from the input for k=1) when rdy[k]. Its valid becomes the upstream valid, or in_valid for k=1. Stage data is held whenever rdy[k]=0.
- Latency and throughput: with out_ready=1 throughout, an operand set accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. it is visible in the cycle following the STAGES-th edge counting the accept edge as 1. Throughput is 1 op/cycle.
- Output stability: while out_valid&&!out_ready, result, carry_out and overflow are held stable.
- Ordering: strict FIFO. No drop, no duplication.
- Full condition: when all STAGES stages are valid and out_ready=0, in_ready=0. A simultaneous output transfer and input transfer on one edge is legal when full.
- Arithmetic: raw = operand1 ± operand2 computed at N+1 bits.
  - carry_out: add = raw[N]; sub = 1 iff unsigned operand1 < operand2. Computed regardless of SIGNED.
  - overflow, SIGNED=0: equals carry_out.
  - overflow, SIGNED=1: add = both operand MSBs equal and result MSB differs; sub = operand MSBs differ and result MSB differs from operand1 MSB.
  - sat_en=0: result = raw[N-1:0].
  - sat_en=1 and overflow=1, unsigned: add → 2^N-1; sub → 0.
  - sat_en=1 and overflow=1, signed: clamp to 2^(N-1)-1 if the true result is positive, or -2^(N-1) if negative.
  - Flags always report the pre-saturation condition.
- Reset mid-operation: asserting reset_n discards all in-flight data; out_valid drops asynchronously. After release the unit is empty and in_ready=1 from the first cycle. No stale result is ever presented.
- Idle inputs: operand1/operand2/op_sub/sat_en are don't-care when in_valid=0.
- Illegal parameters: STAGES=0 or N<2 trigger an elaboration-time $error.

Test Plan (N=8, STAGES=2 unless noted):
- Reset: hold reset_n=0 for 2 cycles, then release → out_valid=0, result=0, flags=0 during reset; in_ready=1 in the first cycle after release.
- Unsigned add: 200+100, sat_en=0 → result=44, carry_out=1, overflow=1, out_valid exactly 2 edges after accept. Same operands with sat_en=1 → result=255, flags unchanged.
- Unsigned sub: 5-9, sat_en=0 → result=252, carry_out=1, overflow=1. With sat_en=1 → result=0. Then 9-5 → result=4, flags=0.
- SIGNED=1, 8 bit:
  - 100+50, sat_en=0 → result=0x96 (-106), overflow=1.
  - 100+50, sat_en=1 → result=127.
  - -100-50, sat_en=1 → result=0x80 (-128), overflow=1.
  - -3+1 → result=-2, overflow=0.
- Backpressure/throughput:
  - Setup: stream i+1 for i=0..9 back-to-back; drop out_ready for 5 cycles starting at the 3rd output.
  - Required: exactly 10 outputs, values 1..10 in order; in_ready=0 while both stages are full; result stable during the stall.
  - Repeat with STAGES=1 and STAGES=4: identical output sequence, latency = STAGES.
- Reset mid-stream: with 2 operations in flight and out_ready=0, pulse reset_n low asynchronously (between edges) → out_valid=0 immediately; after release no output appears until a new input is accepted; the new input 7+8 → result=15.
